ppg_afe_model: RTL and testbench

PPG_AFE_MODEL -- requirements
Module: ppg_afe_model

---
 rtl/ppg_afe_model_pkg.sv | 18 +
 rtl/ppg_triangle_gen.sv | 37 +++
 rtl/ppg_afe_model.sv | 164 ++++++++++++++++
 tb/tb_ppg_afe_model.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_afe_model_pkg.sv
// Shared definitions for the PPG analog front-end model: LED state
// encoding, ADC mid-scale code and the noise LFSR seed/taps used when
// the design is built with AFE_NOISE_EN.
package ppg_afe_model_pkg;

    typedef enum logic [1:0] {
        ST_DARK   = 2'd0,
        ST_RED    = 2'd1,
        ST_IR     = 2'd2,
        ST_SETTLE = 2'd3
    } led_state_t;

    localparam int          ADC_MID   = 128;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ppg_triangle_gen.sv
// Pulsatile component generator: a symmetric triangle that steps by one
// every STEP_DIV clocks, climbing from 0 to AC_AMP and back down again.
module ppg_triangle_gen #(
    parameter int AC_AMP   = 40,
    parameter int STEP_DIV = 100
) (
    input  logic       CLK,
    input  logic       rst,
    output logic [7:0] ac
);

    logic [15:0] presc;
    logic        dir_down;

    // Prescaler wrap advances the triangle; direction flips at the extremes
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (rst) begin
            presc    <= '0;
            ac       <= '0;
            dir_down <= 1'b0;
        end else if (presc == 16'(STEP_DIV - 1)) begin
            presc <= '0;
            if (dir_down) begin
                ac <= ac - 8'd1;
                if (ac == 8'd1) dir_down <= 1'b0;
            end else begin
                ac <= ac + 8'd1;
                if (ac == 8'(AC_AMP - 1)) dir_down <= 1'b1;
            end
        end else begin
            presc <= presc + 16'd1;
        end
    end

endmodule

// File: rtl/ppg_afe_model.sv
// Behavioural PPG front end: LED sequencing with settling, photodiode
// level, DC offset removal, PGA gain and an 8-bit saturating ADC with a
// two-stage conversion pipeline started by rising edges of CLK_Filter.
// Build option: define AFE_NOISE_EN to add LFSR dither of -2..+1 to pd.
module ppg_afe_model
    import ppg_afe_model_pkg::*;
#(
    parameter int RED_DC     = 600,
    parameter int IR_DC      = 500,
    parameter int AC_AMP     = 40,
    parameter int STEP_DIV   = 100,
    parameter int AMBIENT    = 20,
    parameter int DC_STEP    = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic       LED_IR,
    input  logic       LED_RED,
    input  logic [3:0] PGA_Gain,
    input  logic       CLK_Filter,
    output logic [7:0] ADC,
    output logic       ADC_SAT
);

    logic [7:0]         ac;
    led_state_t         state, target, settle_tgt;
    logic [7:0]         settle_cnt;
    logic [10:0]        red_lvl, ir_lvl, pd;
    logic [4:0]         drive_p1;
    logic [14:0]        red_prod, ir_prod;
    logic signed [11:0] pd_s, v;
    logic [11:0]        comp_amt;
    logic               filt_q, rise;
    logic               s1_valid;
    logic signed [11:0] s1_v;
    logic [3:0]         s1_gain;
    logic signed [15:0] v_ext, gain_p1, amp;
    logic signed [16:0] res;
    logic [7:0]         r_sat;
    logic               r_clip;

    ppg_triangle_gen #(
        .AC_AMP  (AC_AMP),
        .STEP_DIV(STEP_DIV)
    ) u_tri (
        .CLK(CLK),
        .rst(rst),
        .ac (ac)
    );

    // Requested LED state: exactly one LED lit, otherwise dark
    always_comb begin
        // NOTE: default assignment first so no path leaves target unassigned
        // and no latch is inferred.
        target = ST_DARK;
        if (LED_RED && !LED_IR)      target = ST_RED;
        else if (LED_IR && !LED_RED) target = ST_IR;
    end

    // LED state machine: any change of request passes through SETTLE_CYC
    // settling cycles; a new request while settling restarts the count
    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= ST_DARK;
            settle_tgt <= ST_DARK;
            settle_cnt <= '0;
        end else if (state != ST_SETTLE) begin
            if (target != state) begin
                state      <= ST_SETTLE;
                settle_tgt <= target;
                settle_cnt <= 8'(SETTLE_CYC - 1);
            end
        end else if (target != settle_tgt) begin
            settle_tgt <= target;
            settle_cnt <= 8'(SETTLE_CYC - 1);
        end else if (settle_cnt == 8'd0) begin
            state <= settle_tgt;
        end else begin
            settle_cnt <= settle_cnt - 8'd1;
        end
    end

    assign drive_p1 = {1'b0, LED_DRIVE} + 5'd1;
    assign red_lvl  = 11'(RED_DC) + {3'b0, ac};
    assign ir_lvl   = 11'(IR_DC) + {4'b0, ac[7:1]};
    assign red_prod = 15'(red_lvl) * 15'(drive_p1);
    assign ir_prod  = 15'(ir_lvl) * 15'(drive_p1);

    // Photodiode level for the current LED state
    always_comb begin
        pd = 11'(AMBIENT);
        case (state)
            ST_RED:  pd = 11'(red_prod >> 4);
            ST_IR:   pd = 11'(ir_prod >> 4);
            default: pd = 11'(AMBIENT);
        endcase
    end

`ifdef AFE_NOISE_EN
    logic [15:0] lfsr;

    // Dither source: free-running Fibonacci LFSR
    always_ff @(posedge CLK) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign pd_s = signed'({1'b0, pd}) + signed'({10'b0, lfsr[1:0]}) - 12'sd2;
`else
    assign pd_s = signed'({1'b0, pd});
`endif

    assign comp_amt = {5'b0, DC_Comp} * 12'(DC_STEP);
    assign v        = pd_s - signed'(comp_amt);
    assign rise     = CLK_Filter & ~filt_q;

    // Stage 2 arithmetic: gain with floor shift, then mid-scale offset
    assign v_ext   = 16'(s1_v);
    assign gain_p1 = signed'({12'b0, s1_gain}) + 16'sd1;
    assign amp     = (v_ext * gain_p1) >>> 2;
    assign res     = 17'(amp) + 17'(ADC_MID);

    // Clip the result to the 8-bit code range and flag the clip
    always_comb begin
        r_sat  = res[7:0];
        r_clip = 1'b0;
        if (res > 17'sd255) begin
            r_sat  = 8'hFF;
            r_clip = 1'b1;
        end else if (res < 17'sd0) begin
            r_sat  = 8'h00;
            r_clip = 1'b1;
        end
    end

    // Strobe edge detect, sample capture on rise, result update one cycle later
    always_ff @(posedge CLK) begin
        if (rst) begin
            // NOTE: the pipeline data registers are cleared too, so an
            // in-flight sample can never surface after reset.
            filt_q   <= 1'b0;
            s1_valid <= 1'b0;
            s1_v     <= '0;
            s1_gain  <= '0;
            ADC      <= '0;
            ADC_SAT  <= 1'b0;
        end else begin
            filt_q   <= CLK_Filter;
            s1_valid <= rise;
            if (rise) begin
                s1_v    <= v;
                s1_gain <= PGA_Gain;
            end
            if (s1_valid) begin
                ADC     <= r_sat;
                ADC_SAT <= r_clip;
            end
        end
    end

endmodule

// File: tb/tb_ppg_afe_model.sv
// Self-checking bench for ppg_afe_model (default build, no noise).
// u_dut uses default parameters for table vectors and multi-cycle
// sequences; u_fast uses STEP_DIV=1 for triangle timing and a randomized
// run compared against a behavioural reference model.
module tb_ppg_afe_model;

    localparam int RED_DC  = 600;
    localparam int IR_DC   = 500;
    localparam int AC_AMP  = 40;
    localparam int AMBIENT = 20;
    localparam int DC_STEP = 8;
    localparam int SETTLE  = 4;
    localparam int F_STEP  = 1;

    localparam int M_DARK   = 0;
    localparam int M_RED    = 1;
    localparam int M_IR     = 2;
    localparam int M_SETTLE = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic       rst, led_red, led_ir, filter;
    logic [3:0] led_drive, pga_gain;
    logic [6:0] dc_comp;
    logic [7:0] adc;
    logic       adc_sat;

    // Fast-triangle instance signals
    logic       f_rst, f_led_red, f_led_ir, f_filter;
    logic [3:0] f_led_drive, f_pga_gain;
    logic [6:0] f_dc_comp;
    logic [7:0] f_adc;
    logic       f_adc_sat;

    int n_vec = 0;
    int n_err = 0;

    ppg_afe_model u_dut (
        .CLK       (clk),
        .rst       (rst),
        .LED_DRIVE (led_drive),
        .DC_Comp   (dc_comp),
        .LED_IR    (led_ir),
        .LED_RED   (led_red),
        .PGA_Gain  (pga_gain),
        .CLK_Filter(filter),
        .ADC       (adc),
        .ADC_SAT   (adc_sat)
    );

    ppg_afe_model #(.STEP_DIV(F_STEP)) u_fast (
        .CLK       (clk),
        .rst       (f_rst),
        .LED_DRIVE (f_led_drive),
        .DC_Comp   (f_dc_comp),
        .LED_IR    (f_led_ir),
        .LED_RED   (f_led_red),
        .PGA_Gain  (f_pga_gain),
        .CLK_Filter(f_filter),
        .ADC       (f_adc),
        .ADC_SAT   (f_adc_sat)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    // Triangle value after k clock edges since reset release
    function automatic int tri_ac(input int k);
        int steps, m;
        steps = k / F_STEP;
        m     = steps % (2 * AC_AMP);
        return (m <= AC_AMP) ? m : 2 * AC_AMP - m;
    endfunction

    function automatic int target_of(input logic r, input logic i);
        if (r && !i) return M_RED;
        if (i && !r) return M_IR;
        return M_DARK;
    endfunction

    // Full conversion of one sample from the rules in plain arithmetic
    function automatic void model_conv(input int st, input int ac, input int drive,
                                       input int comp, input int gain,
                                       output int code, output int sat);
        int pd, v, a, r;
        case (st)
            M_RED:   pd = ((RED_DC + ac) * (drive + 1)) / 16;
            M_IR:    pd = ((IR_DC + ac / 2) * (drive + 1)) / 16;
            default: pd = AMBIENT;
        endcase
        v = pd - comp * DC_STEP;
        a = v * (gain + 1);
        a = (a >= 0) ? a / 4 : -((-a + 3) / 4);
        r = a + 128;
        sat  = (r < 0 || r > 255) ? 1 : 0;
        code = (r < 0) ? 0 : (r > 255) ? 255 : r;
    endfunction

    int m_hist[$];
    int m_edges, m_st, m_ac;
    bit m_filt_q, m_pend, m_check = 1'b0;
    int m_pend_adc, m_pend_sat, m_exp_adc, m_exp_sat;

    // LED state: the requested LED once the request has been unchanged for
    // SETTLE+1 consecutive sampled edges (reset counts as a dark request)
    function automatic int hist_state();
        foreach (m_hist[i])
            if (m_hist[i] != m_hist[0]) return M_SETTLE;
        return m_hist[0];
    endfunction

    always @(posedge clk) begin
        if (f_rst) begin
            m_edges   = 0;
            m_filt_q  = 1'b0;
            m_pend    = 1'b0;
            m_exp_adc = 0;
            m_exp_sat = 0;
            m_hist.delete();
            for (int i = 0; i <= SETTLE; i++) m_hist.push_back(M_DARK);
        end else begin
            m_st = hist_state();
            m_ac = tri_ac(m_edges);
            if (m_pend) begin
                m_exp_adc = m_pend_adc;
                m_exp_sat = m_pend_sat;
            end
            m_pend = f_filter && !m_filt_q;
            if (m_pend)
                model_conv(m_st, m_ac, int'(f_led_drive), int'(f_dc_comp),
                           int'(f_pga_gain), m_pend_adc, m_pend_sat);
            m_filt_q = f_filter;
            m_edges++;
            m_hist.push_back(target_of(f_led_red, f_led_ir));
            void'(m_hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (m_check) begin
            check("rand_adc", f_adc, m_exp_adc);
            check("rand_sat", f_adc_sat, m_exp_sat);
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        logic       red;
        logic       ir;
        logic [3:0] drive;
        logic [6:0] comp;
        logic [3:0] gain;
        int         exp_adc;
        int         exp_sat;
    } vec_t;

    vec_t vecs[13];

    task automatic reset_main();
        rst    = 1'b1;
        filter = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic reset_fast();
        f_rst    = 1'b1;
        f_filter = 1'b0;
        @(negedge clk);
        f_rst = 1'b0;
    endtask

    function automatic bit is_rise(input int j, input int first);
        return (j >= first && j <= 7 && ((j - first) % 2 == 0));
    endfunction

    function automatic int settle_exp(input int j);
        if (j <= 0) return 178;
        if (j <= 4) return 33;
        return 153;
    endfunction

    // RED -> IR switch sampled at edge c; conversions every other cycle
    // starting at edge c+first
    task automatic settle_seq(input int first);
        reset_main();
        led_red = 1'b1; led_ir = 1'b0; led_drive = 4'd15; dc_comp = 7'd50; pga_gain = 4'd0;
        repeat (8) @(negedge clk);
        for (int j = -2; j <= 9; j++) begin
            led_red = (j < 0);
            led_ir  = (j >= 0);
            filter  = is_rise(j, first);
            @(negedge clk);
            if (is_rise(j - 1, first))
                check($sformatf("settle%0d_j%0d", first, j - 1), adc, settle_exp(j - 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; led_red = 1'b0; led_ir = 1'b0; filter = 1'b0;
        led_drive = '0; dc_comp = '0; pga_gain = '0;
        f_rst = 1'b1; f_led_red = 1'b0; f_led_ir = 1'b0; f_filter = 1'b0;
        f_led_drive = '0; f_dc_comp = '0; f_pga_gain = '0;

        //              red   ir    drv    comp     gain   adc  sat
        vecs[0]  = '{1'b1, 1'b0, 4'd15, 7'd75,  4'd9,  128, 0};
        vecs[1]  = '{1'b1, 1'b0, 4'd15, 7'd0,   4'd0,  255, 1};
        vecs[2]  = '{1'b1, 1'b0, 4'd15, 7'd127, 4'd0,  24,  0};
        vecs[3]  = '{1'b0, 1'b0, 4'd15, 7'd0,   4'd0,  133, 0};
        vecs[4]  = '{1'b1, 1'b1, 4'd15, 7'd0,   4'd0,  133, 0};
        vecs[5]  = '{1'b0, 1'b1, 4'd15, 7'd0,   4'd0,  253, 0};
        vecs[6]  = '{1'b0, 1'b1, 4'd15, 7'd62,  4'd3,  132, 0};
        vecs[7]  = '{1'b1, 1'b0, 4'd7,  7'd37,  4'd15, 144, 0};
        vecs[8]  = '{1'b1, 1'b0, 4'd0,  7'd5,   4'd0,  127, 0};
        vecs[9]  = '{1'b0, 1'b0, 4'd15, 7'd127, 4'd15, 0,   1};
        vecs[10] = '{1'b1, 1'b0, 4'd13, 7'd2,   4'd0,  255, 0};
        vecs[11] = '{1'b1, 1'b0, 4'd13, 7'd1,   4'd0,  255, 1};
        vecs[12] = '{1'b1, 1'b0, 4'd1,  7'd73,  4'd0,  0,   0};

        @(negedge clk);
        reset_main();
        check("reset_adc", adc, 0);
        check("reset_sat", adc_sat, 0);

        // Table vectors: settle the LEDs, one rise, result one cycle later
        for (int i = 0; i < 13; i++) begin
            reset_main();
            led_red = vecs[i].red; led_ir = vecs[i].ir; led_drive = vecs[i].drive;
            dc_comp = vecs[i].comp; pga_gain = vecs[i].gain;
            repeat (8) @(negedge clk);
            filter = 1'b1;
            @(negedge clk);
            filter = 1'b0;
            check($sformatf("vec%0d_latency", i), adc, 0);
            @(negedge clk);
            check($sformatf("vec%0d_adc", i), adc, vecs[i].exp_adc);
            check($sformatf("vec%0d_sat", i), adc_sat, vecs[i].exp_sat);
        end

        // LED switch with back-to-back conversions, both phases
        settle_seq(-1);
        settle_seq(0);

        // Reset between sample capture and result update
        reset_main();
        led_red = 1'b1; led_ir = 1'b0; led_drive = 4'd15; dc_comp = 7'd50; pga_gain = 4'd0;
        repeat (8) @(negedge clk);
        filter = 1'b1; @(negedge clk); filter = 1'b0; @(negedge clk);
        check("rstmid_pre", adc, 178);
        filter = 1'b1; @(negedge clk);
        filter = 1'b0; rst = 1'b1; @(negedge clk);
        rst = 1'b0;
        check("rstmid_adc", adc, 0);
        check("rstmid_sat", adc_sat, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_hold%0d", k), adc, 0);
        end
        filter = 1'b1; @(negedge clk); filter = 1'b0; @(negedge clk);
        check("rstmid_new", adc, 178);

        // Triangle timing with STEP_DIV=1: ADC = 128 + ac in this setup
        rst = 1'b1;
        f_led_red = 1'b1; f_led_ir = 1'b0; f_led_drive = 4'd15; f_dc_comp = 7'd75; f_pga_gain = 4'd3;
        reset_fast();
        repeat (40) @(negedge clk);
        f_filter = 1'b1; @(negedge clk); f_filter = 1'b0; @(negedge clk);
        check("tri_ac40", f_adc, 168);
        repeat (38) @(negedge clk);
        f_filter = 1'b1; @(negedge clk); f_filter = 1'b0; @(negedge clk);
        check("tri_ac80", f_adc, 128);
        reset_fast();
        repeat (81) @(negedge clk);
        f_filter = 1'b1; @(negedge clk); f_filter = 1'b0; @(negedge clk);
        check("tri_ac81", f_adc, 129);

        // Randomized run against the reference model
        reset_fast();
        m_check = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            f_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) {f_led_red, f_led_ir} = 2'($urandom);
            f_led_drive = 4'($urandom);
            f_dc_comp   = 7'($urandom_range(30, 100));
            f_pga_gain  = 4'($urandom);
            f_filter    = 1'($urandom);
            @(negedge clk);
        end
        m_check = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
